pipelined_carry_bypass_adder: RTL and testbench
===============================================

// Module: pipelined_carry_bypass_adder
//
// PURPOSE
// Parametrised, pipelined carry-bypass (carry-skip) adder with valid/ready handshakes on both sides.
// Operand width is split into BLOCK-bit skip groups, and the groups are spread evenly over STAGES
// pipeline segments, so wide adds close timing at full throughput.
// Successor to the single-cycle combinational carry_bypass_adder. Sits between operand-producing
// datapath logic and any result consumer that may apply backpressure.
//
// PARAMETERS
// WIDTH   16  operand/sum width in bits; must be a multiple of BLOCK
// BLOCK   4   bits per carry-bypass group
// STAGES  2   pipeline segments (1..WIDTH/BLOCK); (WIDTH/BLOCK) % STAGES == 0
//
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      asynchronous reset, active high
// in_valid   in   1      operands a/b/cin present
// in_ready   out  1      block accepts operands this cycle
// a          in   WIDTH  operand A (unsigned or two's complement)
// b          in   WIDTH  operand B
// cin        in   1      carry in
// out_valid  out  1      sum/cout valid
// out_ready  in   1      consumer accepts result this cycle
// sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
// cout       out  1      carry out of bit WIDTH-1
// ovf        out  1      signed overflow (only with CBA_OVERFLOW_EN)
//
// BEHAVIOUR
// - Reset: all stage valid bits 0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 after reset.
// - Reset mid-operation: in-flight items are discarded and never emitted.
// - Group logic: p_i = a_i^b_i, g_i = a_i&b_i. Each group ripples internally.
//   Group carry-out = (&p_group) ? group carry-in : ripple carry-out.
// - Segmentation:
//   - Segment k computes groups [k*G, (k+1)*G) with G = WIDTH/BLOCK/STAGES.
//   - Its register holds: low sums done so far, unprocessed upper a/b bits, and the carry into the next segment.
//   - The last segment registers sum/cout/ovf.
// - Latency: exactly STAGES cycles from an accepted input (in_valid&in_ready) to out_valid with out_ready=1.
// - Handshake:
//   - Transfer occurs when valid&ready are both high at a clk edge.
//   - Stage k loads when it is empty or its content moves on this cycle.
//   - in_ready = !v[0] | advance[0]; it is combinational from out_ready through the stage chain.
//   - No combinational path from in_valid/a/b to out_*.
// - Throughput: 1 result per cycle while out_ready=1.
// - Backpressure:
//   - While out_valid & !out_ready, sum/cout/ovf are held stable.
//   - Up to STAGES items are buffered, after which in_ready=0.
//   - Bubbles collapse: an empty stage accepts from the previous stage even when downstream is stalled.
// - Ordering: strict FIFO; no reordering or dropping except on reset.
// - Simultaneous accept and emit on a full pipe is allowed; the pipe stays full.
// - Wrap-around: sum is modulo 2^WIDTH; cout carries the 2^WIDTH term.
//
// CONFIGURATION
// - CBA_OVERFLOW_EN defined:
//   - ovf port exists. ovf = carry into MSB ^ cout, registered alongside sum and held under backpressure.
//   - One extra bit is carried in the last segment register.
// - CBA_OVERFLOW_EN undefined:
//   - ovf port and its logic are absent. All other behaviour is identical.
//
// TESTING (WIDTH=16, BLOCK=4, STAGES=2 unless noted)
// - a=16'hFFFF, b=16'h0001, cin=0 -> 2 cycles later sum=16'h0000, cout=1 (full bypass chain).
// - a=16'h1234, b=16'h4321, cin=1, out_ready=1 -> sum=16'h5556, cout=0 at latency 2.
// - 4 back-to-back inputs, out_ready=1 -> in_ready stays 1; results on 4 consecutive cycles, in order.
// - out_ready=0, in_valid=1 for 5 cycles -> exactly 2 items accepted, then in_ready=0; sum held.
//   Raise out_ready -> both results drain in order, then in_ready returns to 1.
// - rst pulse while 2 items in flight -> out_valid=0 and sum=0 immediately (async);
//   no stale result appears after release.
// - With CBA_OVERFLOW_EN: a=16'h7FFF, b=16'h0001 -> ovf=1, cout=0.
//   a=16'h8000, b=16'h8000 -> ovf=1, cout=1, sum=0.
// - Additionally: 1000 random transactions with random out_ready, checked against a+b+cin,
//   for STAGES in {1,2,4}.

Source files
------------

// File: rtl/pipelined_carry_bypass_adder_if.sv
// Operand/result handshake bundle for pipelined_carry_bypass_adder.
// The ovf signal exists only when CBA_OVERFLOW_EN is defined.
interface pipelined_carry_bypass_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CBA_OVERFLOW_EN
    logic             ovf;
`endif

    // Environment side: produces operands, consumes results.
    modport master (
`ifdef CBA_OVERFLOW_EN
        input  ovf,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    // Adder side.
    modport slave (
`ifdef CBA_OVERFLOW_EN
        output ovf,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_carry_bypass_adder.sv
// Pipelined carry-bypass adder: BLOCK-bit skip groups spread over STAGES segments, valid/ready both sides.
// Define CBA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_carry_bypass_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input logic                          clk,
    input logic                          rst,
    pipelined_carry_bypass_adder_if.slave bus
);
    localparam int unsigned SEG_BITS = WIDTH / STAGES;
    localparam int unsigned GPS      = SEG_BITS / BLOCK;

    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic             ld    [STAGES];
    logic             v_src [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             c_src [STAGES];
`ifdef CBA_OVERFLOW_EN
    logic             ovf_q;
    logic             ovf_d;
`endif

    // Segment k consumes whatever sits in front of it: the ports for k=0, register k-1 otherwise.
    assign v_src[0] = bus.in_valid;
    assign a_src[0] = bus.a;
    assign b_src[0] = bus.b;
    assign s_src[0] = '0;
    assign c_src[0] = bus.cin;

    for (genvar k = 1; k < STAGES; k++) begin : g_src
        assign v_src[k] = v_q[k-1];
        assign a_src[k] = a_q[k-1];
        assign b_src[k] = b_q[k-1];
        assign s_src[k] = s_q[k-1];
        assign c_src[k] = c_q[k-1];
    end

    // A stage loads when empty or when its content leaves; walked from the output back.
    always_comb begin : handshake
        logic r;
        r = bus.out_ready;
        for (int unsigned j = 0; j < STAGES; j++) begin
            ld[STAGES-1-j] = !v_q[STAGES-1-j] || r;
            r              = ld[STAGES-1-j];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            v_d[k] = ld[k] ? v_src[k] : v_q[k];
        end
    end

    always_comb begin : datapath
        logic [WIDTH-1:0] s;
        logic             c;
        logic             gc;
        logic             r;
        logic             p;
        logic             g;
        logic             allp;
        int unsigned      idx;
`ifdef CBA_OVERFLOW_EN
        logic             cmsb;
        cmsb = 1'b0;
`endif
        s    = '0;
        c    = 1'b0;
        gc   = 1'b0;
        r    = 1'b0;
        p    = 1'b0;
        g    = 1'b0;
        allp = 1'b0;
        idx  = 0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_d[k] = a_src[k];
            b_d[k] = b_src[k];
            s      = s_src[k];
            c      = c_src[k];
            for (int unsigned gi = 0; gi < GPS; gi++) begin
                gc   = c;
                r    = c;
                allp = 1'b1;
                for (int unsigned t = 0; t < BLOCK; t++) begin
                    idx = k * SEG_BITS + gi * BLOCK + t;
                    p   = a_src[k][idx] ^ b_src[k][idx];
                    g   = a_src[k][idx] & b_src[k][idx];
`ifdef CBA_OVERFLOW_EN
                    if (idx == WIDTH - 1) cmsb = r;
`endif
                    s[idx] = p ^ r;
                    r      = g | (p & r);
                    allp   = allp & p;
                end
                // Fully propagating group forwards its carry-in straight past the ripple chain.
                c = allp ? gc : r;
            end
            s_d[k] = s;
            c_d[k] = c;
        end
`ifdef CBA_OVERFLOW_EN
        ovf_d = cmsb ^ c_d[STAGES-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
`ifdef CBA_OVERFLOW_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                if (ld[k] && v_src[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
`ifdef CBA_OVERFLOW_EN
            if (ld[STAGES-1] && v_src[STAGES-1]) ovf_q <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
`ifdef CBA_OVERFLOW_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// Bench for pipelined_carry_bypass_adder: directed vectors on a STAGES=2 instance plus
// randomized traffic against a queue-based arithmetic model for STAGES 1, 2 and 4.
module tb_pipelined_carry_bypass_adder;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result model: {ovf, cout, sum} from plain arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        logic       ov;
        t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {ov, t};
    endfunction

    logic rst;
    pipelined_carry_bypass_adder_if #(.WIDTH(W)) dbus ();
    pipelined_carry_bypass_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dbus)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int unsigned S = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        logic rrst;
        logic done = 1'b0;
        pipelined_carry_bypass_adder_if #(.WIDTH(W)) rbus ();
        pipelined_carry_bypass_adder #(.WIDTH(W), .BLOCK(4), .STAGES(S)) u_rdut (
            .clk (clk),
            .rst (rrst),
            .bus (rbus)
        );

        initial begin : drive
            logic [W+1:0] q[$];
            logic [W+1:0] e;
            int unsigned  sent;
            int unsigned  cyc;
            sent = 0;
            cyc  = 0;
            rrst = 1'b1;
            rbus.in_valid  = 1'b0;
            rbus.a         = '0;
            rbus.b         = '0;
            rbus.cin       = 1'b0;
            rbus.out_ready = 1'b0;
            repeat (2) @(negedge clk);
            rrst = 1'b0;
            while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                rbus.out_ready = ($urandom_range(0, 3) != 0);
                rbus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                rbus.a         = W'($urandom);
                rbus.b         = W'($urandom);
                rbus.cin       = 1'($urandom);
                #1;
                // Any free slot anywhere in the pipe, or a draining output, opens the input.
                check_eq($sformatf("s%0d_in_ready", S), 32'(rbus.in_ready),
                         32'((q.size() < S) || rbus.out_ready));
                if (rbus.out_valid) begin
                    if (q.size() == 0) begin
                        check_eq($sformatf("s%0d_spurious_valid", S), 32'(rbus.out_valid), 32'd0);
                    end else begin
                        e = q[0];
                        check_eq($sformatf("s%0d_result", S), 32'({rbus.cout, rbus.sum}), 32'(e[W:0]));
`ifdef CBA_OVERFLOW_EN
                        check_eq($sformatf("s%0d_ovf", S), 32'(rbus.ovf), 32'(e[W+1]));
`endif
                        if (rbus.out_ready) void'(q.pop_front());
                    end
                end
                if (rbus.in_valid && rbus.in_ready) begin
                    q.push_back(ref_add(rbus.a, rbus.b, rbus.cin));
                    sent++;
                end
            end
            check_eq($sformatf("s%0d_sent", S), sent, 32'd1000);
            check_eq($sformatf("s%0d_drained", S), 32'(q.size()), 32'd0);
            @(negedge clk);
            rbus.in_valid = 1'b0;
            done = 1'b1;
        end
    end

    task automatic step(input logic orr);
        @(negedge clk);
        dbus.out_ready = orr;
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        dbus.in_valid = v;
        dbus.a        = a;
        dbus.b        = b;
        dbus.cin      = c;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [W+1:0] e);
        check_eq({tag, "_valid"}, 32'(dbus.out_valid), 32'(v));
        if (v) begin
            check_eq({tag, "_sum"}, 32'({dbus.cout, dbus.sum}), 32'(e[W:0]));
`ifdef CBA_OVERFLOW_EN
            check_eq({tag, "_ovf"}, 32'(dbus.ovf), 32'(e[W+1]));
`endif
        end
    endtask

    task automatic one_shot(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W+1:0] e);
        step(1'b1);
        check_eq({tag, "_in_ready"}, 32'(dbus.in_ready), 32'd1);
        drive(1'b1, a, b, c);
        step(1'b1);
        check_eq({tag, "_lat1_valid"}, 32'(dbus.out_valid), 32'd0);
        drive(1'b0, a, b, c);
        step(1'b1);
        chk_out(tag, 1'b1, e);
        step(1'b1);
        check_eq({tag, "_after_valid"}, 32'(dbus.out_valid), 32'd0);
    endtask

    initial begin : directed
        logic [W+1:0] ex [6];
        logic [W-1:0] xa [6];
        logic [W-1:0] xb [6];
        logic         xc [6];
        int unsigned  w;

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        dbus.out_ready = 1'b0;
        #1;
        chk_out("reset", 1'b0, '0);
        check_eq("reset_sum", 32'({dbus.cout, dbus.sum}), 32'd0);
`ifdef CBA_OVERFLOW_EN
        check_eq("reset_ovf", 32'(dbus.ovf), 32'd0);
`endif
        check_eq("reset_in_ready", 32'(dbus.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        one_shot("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
        one_shot("1234_4321", 16'h1234, 16'h4321, 1'b1, {1'b0, 1'b0, 16'h5556});
        one_shot("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        one_shot("8000_8000", 16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});

        // Back-to-back stream: item i shows at the output two negedges after it is driven.
        for (int unsigned i = 0; i < 4; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
            xc[i] = 1'($urandom);
            ex[i] = ref_add(xa[i], xb[i], xc[i]);
        end
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1);
            if (i >= 2) chk_out($sformatf("b2b%0d", i - 2), 1'b1, ex[i-2]);
            else        chk_out("b2b_fill", 1'b0, '0);
            if (i < 4) begin
                check_eq("b2b_in_ready", 32'(dbus.in_ready), 32'd1);
                drive(1'b1, xa[i], xb[i], xc[i]);
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
        end
        step(1'b1);
        chk_out("b2b_empty", 1'b0, '0);

        // Stalled output: two items fill the pipe, the rest are refused, output held.
        for (int unsigned i = 0; i < 5; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
            xc[i] = 1'($urandom);
            ex[i] = ref_add(xa[i], xb[i], xc[i]);
        end
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b0);
            check_eq($sformatf("bp_in_ready%0d", i), 32'(dbus.in_ready), 32'(i < 2));
            if (i >= 2) chk_out($sformatf("bp_hold%0d", i), 1'b1, ex[0]);
            else        chk_out("bp_fill", 1'b0, '0);
            drive(1'b1, xa[i], xb[i], xc[i]);
        end
        step(1'b0);
        chk_out("bp_hold5", 1'b1, ex[0]);
        drive(1'b0, '0, '0, 1'b0);
        dbus.out_ready = 1'b1;
        step(1'b1);
        chk_out("bp_drain1", 1'b1, ex[1]);
        step(1'b1);
        chk_out("bp_drained", 1'b0, '0);
        check_eq("bp_in_ready_back", 32'(dbus.in_ready), 32'd1);

        // Reset with two items in flight.
        step(1'b0);
        drive(1'b1, 16'h0123, 16'h0456, 1'b0);
        step(1'b0);
        drive(1'b1, 16'h0321, 16'h0654, 1'b1);
        step(1'b0);
        drive(1'b0, '0, '0, 1'b0);
        chk_out("rst_pre", 1'b1, ref_add(16'h0123, 16'h0456, 1'b0));
        rst = 1'b1;
        #1;
        check_eq("rst_async_valid", 32'(dbus.out_valid), 32'd0);
        check_eq("rst_async_sum", 32'({dbus.cout, dbus.sum}), 32'd0);
        check_eq("rst_async_in_ready", 32'(dbus.in_ready), 32'd1);
        step(1'b1);
        rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b1);
            check_eq("rst_no_stale", 32'(dbus.out_valid), 32'd0);
        end

        w = 0;
        while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && w < 30000) begin
            @(negedge clk);
            w++;
        end
        check_eq("rand_done", 32'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
